// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: FIFO-buffered PS/2 device-to-host keyboard frame transmitter.
// Define PS2_ERR_INJECT_EN to store err_i per entry and send that frame with inverted parity.
module ps2_kbd_tx #(
    parameter int CLK_DIV    = 2000,
    parameter int GAP_CYCLES = 100,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset_n_i,
    input  logic [7:0] code_i,
    input  logic       strobe_i,
    input  logic       err_i,
    output logic       ps2_clk_o,
    output logic       ps2_data_o,
    output logic       busy_o,
    output logic       overflow_o
);
`ifdef PS2_ERR_INJECT_EN
    localparam int W = 9;
`else
    localparam int W = 8;
`endif
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CMAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, BIT_HI, BIT_LO, GAP} state_e;

    logic [W-1:0]  mem_q [FIFO_DEPTH];
    logic [AW:0]   wp_q, wp_d, rp_q, rp_d;
    logic [W-1:0]  din, dout;
    logic          empty, full, push, pop, parity, cnt_hit, gap_hit;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [10:0]   frame_q, frame_d;
    logic          clk_q, clk_d, data_q, data_d, busy_q, busy_d, ovf_q, ovf_d;

`ifdef PS2_ERR_INJECT_EN
    assign din    = {err_i, code_i};
    assign parity = (~^dout[7:0]) ^ dout[8];
`else
    logic unused_err;
    assign unused_err = err_i;
    assign din    = code_i;
    assign parity = ~^dout[7:0];
`endif

    assign empty   = wp_q == rp_q;
    assign full    = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
    assign dout    = mem_q[rp_q[AW-1:0]];
    assign cnt_hit = cnt_q == CW'(CLK_DIV - 1);
    assign gap_hit = cnt_q == CW'(GAP_CYCLES - 1);

    // A pending entry is popped from IDLE or straight out of the gap, so back-to-back frames are spaced by exactly the gap.
    assign pop  = !empty && (state_q == IDLE || (state_q == GAP && gap_hit));
    assign push = strobe_i && (!full || pop);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        frame_d = frame_q;
        case (state_q)
            IDLE:   cnt_d = '0;
            BIT_HI: if (cnt_hit) begin
                state_d = BIT_LO;
                cnt_d   = '0;
            end
            BIT_LO: if (cnt_hit) begin
                cnt_d   = '0;
                state_d = (idx_q == 4'd10) ? GAP : BIT_HI;
                idx_d   = (idx_q == 4'd10) ? idx_q : idx_q + 4'd1;
            end
            default: if (gap_hit) begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        if (pop) begin
            state_d = BIT_HI;
            cnt_d   = '0;
            idx_d   = '0;
            frame_d = {1'b1, parity, dout[7:0], 1'b0};
        end
    end

    always_comb begin
        wp_d   = wp_q + (AW + 1)'(push);
        rp_d   = rp_q + (AW + 1)'(pop);
        ovf_d  = ovf_q | (strobe_i & full & ~pop);
        clk_d  = state_q != BIT_LO;
        data_d = (state_q == BIT_HI || state_q == BIT_LO) ? frame_q[idx_q] : 1'b1;
        busy_d = strobe_i | ~empty | (state_q != IDLE);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wp_q[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            frame_q <= '1;
            wp_q    <= '0;
            rp_q    <= '0;
            clk_q   <= 1'b1;
            data_q  <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            clk_q   <= clk_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ps2_clk_o  = clk_q;
    assign ps2_data_o = data_q;
    assign busy_o     = busy_q;
    assign overflow_o = ovf_q;
endmodule

// File: tb/tb_ps2_kbd_tx.sv
// tb_ps2_kbd_tx: directed bench for ps2_kbd_tx at CLK_DIV=4, GAP_CYCLES=8, FIFO_DEPTH=8.
module tb_ps2_kbd_tx;
    localparam int CLK_DIV = 4;
`ifdef PS2_ERR_INJECT_EN
    localparam logic ERR_PAR = 1'b0;
`else
    localparam logic ERR_PAR = 1'b1;
`endif

    typedef struct {
        logic [7:0] code;
        logic       err;
        logic       par;
    } vec_t;

    logic       clk = 1'b0, reset_n_i = 1'b0, strobe_i = 1'b0, err_i = 1'b0;
    logic [7:0] code_i = 8'h00;
    logic       ps2_clk_o, ps2_data_o, busy_o, overflow_o;
    int         checks = 0, failures = 0;

    always #5 clk = ~clk;

    ps2_kbd_tx #(.CLK_DIV(4), .GAP_CYCLES(8), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset_n_i(reset_n_i), .code_i(code_i), .strobe_i(strobe_i), .err_i(err_i),
        .ps2_clk_o(ps2_clk_o), .ps2_data_o(ps2_data_o), .busy_o(busy_o), .overflow_o(overflow_o)
    );

    // Line monitor: shifts in data at each clock fall, checks every low pulse width and data stability.
    logic [10:0] frames[$];
    logic [10:0] sh = '0;
    int          nbits = 0, low_run = 0, hi_run = 0, last_gap = -1;
    logic        prev_clk = 1'b1, prev_data = 1'b1, fall_data = 1'b1, stable = 1'b1;

    always @(posedge clk) begin
        #1;
        if (!reset_n_i) begin
            nbits = 0; low_run = 0; hi_run = 0; prev_clk = 1'b1; prev_data = 1'b1;
        end else begin
            if (ps2_clk_o && prev_data && !ps2_data_o && nbits == 0) last_gap = hi_run;
            if (!ps2_clk_o && prev_clk) begin
                sh = {ps2_data_o, sh[10:1]}; nbits++; fall_data = ps2_data_o; stable = 1'b1; low_run = 0;
                if (nbits == 11) begin frames.push_back(sh); nbits = 0; end
            end
            if (!ps2_clk_o) begin
                low_run++; hi_run = 0;
                if (ps2_data_o != fall_data) stable = 1'b0;
            end else begin
                if (!prev_clk) begin
                    checks++;
                    if (low_run != CLK_DIV || !stable) begin
                        failures++;
                        $display("FAIL clk_low_pulse width=%0d stable=%0d required width=%0d stable=1", low_run, stable, CLK_DIV);
                    end
                end
                hi_run++;
            end
            prev_clk = ps2_clk_o; prev_data = ps2_data_o;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push(input logic [7:0] c, input logic e);
        code_i = c; err_i = e; strobe_i = 1'b1;
        tick(1);
        strobe_i = 1'b0; err_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy_o && n < budget) begin tick(1); n++; end
        checks++;
        if (busy_o) begin
            failures++;
            $display("FAIL wait_idle busy_o still 1 after %0d cycles, expected 0", budget);
        end
    endtask

    function automatic logic [10:0] fr(input int i);
        return (i < frames.size()) ? frames[i] : 11'h000;
    endfunction

    initial begin
        vec_t tbl[8];
        tbl[0] = '{8'h1C, 1'b0, 1'b0};
        tbl[1] = '{8'hF0, 1'b0, 1'b1};
        tbl[2] = '{8'h00, 1'b0, 1'b1};
        tbl[3] = '{8'hFF, 1'b0, 1'b1};
        tbl[4] = '{8'h01, 1'b0, 1'b0};
        tbl[5] = '{8'hA5, 1'b0, 1'b1};
        tbl[6] = '{8'h7F, 1'b0, 1'b0};
        tbl[7] = '{8'h00, 1'b1, ERR_PAR};

        tick(2);
        chk("rst_ps2_clk", ps2_clk_o, 1);
        chk("rst_ps2_data", ps2_data_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_overflow", overflow_o, 0);

        // Push on the very first edge after release, then check latency and busy timing.
        reset_n_i = 1'b1;
        push(8'h1C, 1'b0);
        chk("lat_edge_n", ps2_data_o, 1);
        tick(1);
        chk("lat_edge_n1", ps2_data_o, 1);
        tick(1);
        chk("lat_edge_n2_start", ps2_data_o, 0);
        chk("lat_edge_n2_clk", ps2_clk_o, 1);
        tick(95);
        chk("busy_n97", busy_o, 1);
        tick(1);
        chk("busy_n98", busy_o, 0);
        chk("frame_1c_count", frames.size(), 1);
        chk("frame_1c_bits", fr(0), 11'b10000111000);

        for (int i = 0; i < 8; i++) begin
            frames.delete();
            push(tbl[i].code, tbl[i].err);
            wait_idle(300);
            chk($sformatf("tbl%0d_count", i), frames.size(), 1);
            chk($sformatf("tbl%0d_frame", i), fr(0), {1'b1, tbl[i].par, tbl[i].code, 1'b0});
        end

        frames.delete();
        push(8'hF0, 1'b0);
        push(8'h1C, 1'b0);
        wait_idle(400);
        chk("b2b_count", frames.size(), 2);
        chk("b2b_frame0", fr(0), {1'b1, 1'b1, 8'hF0, 1'b0});
        chk("b2b_frame1", fr(1), {1'b1, 1'b0, 8'h1C, 1'b0});
        chk("b2b_gap", last_gap, 8);

        chk("ovf_before", overflow_o, 0);
        frames.delete();
        for (int i = 0; i < 10; i++) begin
            push(8'h10 + 8'(i), 1'b0);
            if (i == 8) chk("ovf_after_9th", overflow_o, 0);
        end
        chk("ovf_after_10th", overflow_o, 1);
        wait_idle(1500);
        chk("ovf_frame_count", frames.size(), 9);
        for (int j = 0; j < 9; j++) begin
            logic [10:0] f;
            f = fr(j);
            chk($sformatf("ovf_data%0d", j), f[8:1], 8'h10 + 8'(j));
            chk($sformatf("ovf_fmt%0d", j), {f[10], f[0], ^f[9:1]}, 3'b101);
        end
        chk("ovf_sticky", overflow_o, 1);

        // Abort a frame while the clock is low during data bit 4.
        frames.delete();
        push(8'h00, 1'b0);
        tick(46);
        chk("abort_pre_clk", ps2_clk_o, 0);
        chk("abort_pre_data", ps2_data_o, 0);
        #2 reset_n_i = 1'b0;
        #1;
        chk("abort_clk", ps2_clk_o, 1);
        chk("abort_data", ps2_data_o, 1);
        chk("abort_busy", busy_o, 0);
        chk("abort_overflow", overflow_o, 0);
        tick(3);
        reset_n_i = 1'b1;
        tick(200);
        chk("abort_no_frames", frames.size(), 0);
        chk("abort_no_partial", nbits, 0);
        chk("abort_idle_busy", busy_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ps2_kbd_tx.md
PS2_KBD_TX -- requirements
Module: ps2_kbd_tx

Interface
REQ-001 Parameters (name, default, meaning): CLK_DIV, 2000, clk cycles per PS/2 clock half-period; min 2.
REQ-002 GAP_CYCLES, 100, idle clk cycles after each frame's stop bit; min 1.
REQ-003 FIFO_DEPTH, 8, scancode FIFO entries; power of two, min 2.
REQ-004 Ports (name, direction, width, meaning): clk, input, 1, sole clock, all logic on rising edge.
REQ-005 reset_n_i, input, 1, asynchronous active-low reset.
REQ-006 code_i, input, 8, scancode byte; valid when strobe_i is high.
REQ-007 strobe_i, input, 1, single-cycle push of code_i.
REQ-008 err_i, input, 1, parity-error injection request, qualified by strobe_i.
REQ-009 ps2_clk_o, output, 1, device-driven PS/2 clock line, idle high.
REQ-010 ps2_data_o, output, 1, device-driven PS/2 data line, idle high.
REQ-011 busy_o, output, 1, high while the FIFO is non-empty or a frame/gap is in progress.
REQ-012 overflow_o, output, 1, sticky flag: a push was dropped.

Function
REQ-013 Block is the upstream keyboard emulator feeding the system's PS/2 keyboard port; it converts strobed scancodes into serial PS/2 device-to-host frames.
REQ-014 strobe_i high with FIFO not full: {err_i, code_i} written at that edge.
REQ-015 strobe_i high with FIFO full and no pop in the same cycle: byte dropped, overflow_o set at that edge.
REQ-016 Simultaneous push and pop with FIFO full: push accepted, no overflow.
REQ-017 FSM states: IDLE, BIT_HI, BIT_LO, GAP.
REQ-018 IDLE with FIFO non-empty: pop entry, load 11-bit frame {stop=1, parity, data[7:0], start=0}, bit index 0, enter BIT_HI.
REQ-019 Frame bits sent LSB first: start, data[0..7], parity, stop.
REQ-020 Parity is odd: parity bit = ~^data (total ones across data+parity odd).
REQ-021 BIT_HI: ps2_clk_o=1, ps2_data_o=current bit, for CLK_DIV cycles; then BIT_LO.
REQ-022 BIT_LO: ps2_clk_o=0, ps2_data_o held, for CLK_DIV cycles; then next bit in BIT_HI, or GAP after bit 10.
REQ-023 GAP: both lines high for GAP_CYCLES cycles; then IDLE.
REQ-024 Frame duration 22*CLK_DIV cycles plus GAP_CYCLES.
REQ-025 Latency: with FSM in IDLE and FIFO empty, strobe sampled at edge N -> ps2_data_o low from edge N+2.
REQ-026 ps2_clk_o and ps2_data_o are registered outputs; no combinational path from any input.
REQ-027 Data never changes while ps2_clk_o is low.
REQ-028 FIFO order strictly first-in first-out; no byte reordered or duplicated.

Reset
REQ-029 reset_n_i low, asynchronous: ps2_clk_o=1, ps2_data_o=1, busy_o=0, overflow_o=0, FIFO empty, FSM IDLE.
REQ-030 Reset mid-frame aborts the frame immediately; no partial frame resumes after release.
REQ-031 First push accepted on the first rising edge with reset_n_i high.

Configuration
REQ-032 Macro PS2_ERR_INJECT_EN defined: err_i stored per entry; frame sent with parity bit inverted when its stored flag is 1.
REQ-033 PS2_ERR_INJECT_EN undefined: err_i ignored, FIFO 8 bits wide, parity always correct.

Verification
REQ-034 CLK_DIV=4, GAP_CYCLES=8; push 0x1C -> data sequence 0,0,0,1,1,1,0,0,0,0,1, 11 clk low pulses of 4 cycles, busy_o low 96 cycles after push+2.
REQ-035 Push 0xF0 then 0x1C on consecutive cycles -> two frames, parity 1 then 0, separated by exactly 8 idle cycles.
REQ-036 FIFO_DEPTH=8; push 10 bytes back-to-back while idle -> first popped immediately, 9 stored (8 in FIFO... last dropped), overflow_o=1, exactly 9 frames emitted.
REQ-037 PS2_ERR_INJECT_EN defined; push 0x00 with err_i=1 -> parity bit 0; same without macro -> parity bit 1.
REQ-038 Assert reset_n_i low during data bit 4 of a frame -> both lines high same cycle, busy_o=0, no further frames after release.
